// File: rtl/full_adder_pkg.sv
// Shared defaults and slice-geometry helpers for the pipelined full adder.
package full_adder_pkg;

  localparam int unsigned DefWidth  = 1;
  localparam int unsigned DefStages = 1;

  // Bits of the carry chain handled by each pipeline stage (ceiling division).
  function automatic int unsigned slice_width(input int unsigned width,
                                              input int unsigned stages);
    return (width + stages - 1) / stages;
  endfunction

  function automatic int unsigned stage_of_bit(input int unsigned bit_idx,
                                               input int unsigned width,
                                               input int unsigned stages);
    return bit_idx / slice_width(width, stages);
  endfunction

endpackage

// File: rtl/full_adder_fa_cell.sv
// One-bit combinational full-adder cell; the ripple chain is built from these.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/full_adder.sv
// Pipelined ripple-carry adder: the carry chain is cut into STAGES slices, with
// operand bits delayed ahead of their slice and sum bits delayed behind it.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned STAGES = DefStages
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int unsigned SliceW   = slice_width(WIDTH, STAGES);
  localparam int unsigned MsbStage = stage_of_bit(WIDTH - 1, WIDTH, STAGES);
  localparam int unsigned MsbDepth = STAGES - MsbStage;

  // v_pipe[k] is the valid bit presented to stage k; v_pipe[STAGES] is the output.
  logic [STAGES-1:0] valid_q;
  logic [STAGES:0]   v_pipe;

  assign v_pipe    = {valid_q, in_valid};
  assign out_valid = v_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= v_pipe[STAGES-1:0];
    end
  end

  logic [WIDTH-1:0] cell_x;
  logic [WIDTH-1:0] cell_y;
  logic [WIDTH-1:0] cell_ci;
  logic [WIDTH-1:0] cell_s;
  logic [WIDTH-1:0] cell_co;
  logic [MsbStage:0] stage_ci;

  assign stage_ci[0] = Cin;

  // Carry leaving slice k-1 is registered and feeds the first cell of slice k.
  for (genvar k = 1; k <= MsbStage; k++) begin : g_carry
    logic carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        carry_q <= 1'b0;
      end else if (v_pipe[k-1]) begin
        carry_q <= cell_co[k*SliceW-1];
      end
    end

    assign stage_ci[k] = carry_q;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    localparam int unsigned St    = stage_of_bit(i, WIDTH, STAGES);
    localparam int unsigned Depth = STAGES - St;

    logic [St:0]    x_sh;
    logic [St:0]    y_sh;
    logic [Depth-1:0] s_q;
    logic [Depth:0]   s_sh;

    if (St == 0) begin : g_direct
      assign x_sh = X[i];
      assign y_sh = Y[i];
    end else begin : g_delay
      logic [St-1:0] x_q;
      logic [St-1:0] y_q;

      assign x_sh = {x_q, X[i]};
      assign y_sh = {y_q, Y[i]};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_q <= '0;
          y_q <= '0;
        end else begin
          for (int unsigned j = 0; j < St; j++) begin
            if (v_pipe[j]) begin
              x_q[j] <= x_sh[j];
              y_q[j] <= y_sh[j];
            end
          end
        end
      end
    end

    assign cell_x[i] = x_sh[St];
    assign cell_y[i] = y_sh[St];

    if (i % SliceW == 0) begin : g_slice_head
      assign cell_ci[i] = stage_ci[St];
    end else begin : g_slice_body
      assign cell_ci[i] = cell_co[i-1];
    end

    fa_cell u_cell (
      .x  (cell_x[i]),
      .y  (cell_y[i]),
      .ci (cell_ci[i]),
      .s  (cell_s[i]),
      .co (cell_co[i])
    );

    // Completed sum bit rides the remaining stages; the last register is the output.
    assign s_sh = {s_q, cell_s[i]};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= '0;
      end else begin
        for (int unsigned j = 0; j < Depth; j++) begin
          if (v_pipe[St+j]) begin
            s_q[j] <= s_sh[j];
          end
        end
      end
    end

    assign Sum[i] = s_sh[Depth];
  end

  // Cout and Ovf are both known once the MSB slice resolves.
  logic [MsbDepth-1:0] co_q;
  logic [MsbDepth-1:0] ov_q;
  logic [MsbDepth:0]   co_sh;
  logic [MsbDepth:0]   ov_sh;

  assign co_sh = {co_q, cell_co[WIDTH-1]};
  assign ov_sh = {ov_q, cell_ci[WIDTH-1] ^ cell_co[WIDTH-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      co_q <= '0;
      ov_q <= '0;
    end else begin
      for (int unsigned j = 0; j < MsbDepth; j++) begin
        if (v_pipe[MsbStage+j]) begin
          co_q[j] <= co_sh[j];
          ov_q[j] <= ov_sh[j];
        end
      end
    end
  end

  assign Cout = co_sh[MsbDepth];
  assign Ovf  = ov_sh[MsbDepth];

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for three full_adder configurations sharing one clock and reset.
module tb_full_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic        iv1, x1, y1, c1, ov1, s1, co1, of1;
  logic        iv8, c8, ov8, co8, of8;
  logic [7:0]  x8, y8, s8;
  logic        iv16, c16, ov16, co16, of16;
  logic [15:0] x16, y16, s16;

  full_adder #(.WIDTH(1), .STAGES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .X(x1), .Y(y1), .Cin(c1),
    .out_valid(ov1), .Sum(s1), .Cout(co1), .Ovf(of1)
  );

  full_adder #(.WIDTH(8), .STAGES(4)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .X(x8), .Y(y8), .Cin(c8),
    .out_valid(ov8), .Sum(s8), .Cout(co8), .Ovf(of8)
  );

  full_adder #(.WIDTH(16), .STAGES(4)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .X(x16), .Y(y16), .Cin(c16),
    .out_valid(ov16), .Sum(s16), .Cout(co16), .Ovf(of16)
  );

  typedef struct {
    logic [16:0] full;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];
  exp_t q16[$];

  // Reference: exact integer sum; overflow when same-sign operands give a result of other sign.
  function automatic exp_t model(input int w, input int st, input logic [15:0] x,
                                 input logic [15:0] y, input logic c);
    exp_t e;
    e.full = 17'(x) + 17'(y) + 17'(c);
    e.ovf  = (x[w-1] == y[w-1]) && (e.full[w-1] != x[w-1]);
    e.due  = cyc + st;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cmp_out(input string tag, input logic [16:0] got, input logic got_ovf,
                         input exp_t e);
    checks++;
    assert (got === e.full) else begin
      failures++;
      $error("FAIL %s_sum got=%0h exp=%0h", tag, got, e.full);
    end
    checks++;
    assert (got_ovf === e.ovf) else begin
      failures++;
      $error("FAIL %s_ovf got=%0b exp=%0b", tag, got_ovf, e.ovf);
    end
    checks++;
    assert (cyc === e.due) else begin
      failures++;
      $error("FAIL %s_latency got=%0d exp=%0d", tag, cyc, e.due);
    end
  endtask

  always @(negedge clk) begin
    if (ov1) begin
      checks++;
      assert (q1.size() > 0) else begin
        failures++;
        $error("FAIL w1_unexpected_valid got=1 exp=0");
      end
      if (q1.size() > 0) cmp_out("w1", {15'b0, co1, s1}, of1, q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (ov8) begin
      checks++;
      assert (q8.size() > 0) else begin
        failures++;
        $error("FAIL w8_unexpected_valid got=1 exp=0");
      end
      if (q8.size() > 0) cmp_out("w8", {8'b0, co8, s8}, of8, q8.pop_front());
    end
  end

  always @(negedge clk) begin
    if (ov16) begin
      checks++;
      assert (q16.size() > 0) else begin
        failures++;
        $error("FAIL w16_unexpected_valid got=1 exp=0");
      end
      if (q16.size() > 0) cmp_out("w16", {co16, s16}, of16, q16.pop_front());
    end
  end

  int run16      = 0;
  int last_run16 = 0;
  always @(negedge clk) begin
    if (ov16) begin
      run16++;
    end else begin
      if (run16 != 0) last_run16 = run16;
      run16 = 0;
    end
  end

  logic [1:0] tt [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

  task automatic op1(input int idx);
    exp_t e;
    logic [2:0] v;
    v = 3'(idx);
    @(negedge clk);
    iv1 = 1'b1; x1 = v[2]; y1 = v[1]; c1 = v[0];
    e = model(1, 1, {15'b0, v[2]}, {15'b0, v[1]}, v[0]);
    e.full = {15'b0, tt[idx]};
    q1.push_back(e);
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c);
    @(negedge clk);
    iv8 = 1'b1; x8 = x; y8 = y; c8 = c;
    q8.push_back(model(8, 4, {8'b0, x}, {8'b0, y}, c));
  endtask

  task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic c);
    @(negedge clk);
    iv16 = 1'b1; x16 = x; y16 = y; c16 = c;
    q16.push_back(model(16, 4, x, y, c));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      iv1 = 1'b0; iv8 = 1'b0; iv16 = 1'b0;
    end
  endtask

  initial begin
    int pulses;
    int stale;
    iv1 = 0; x1 = 0; y1 = 0; c1 = 0;
    iv8 = 0; x8 = 0; y8 = 0; c8 = 0;
    iv16 = 0; x16 = 0; y16 = 0; c16 = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_w1_outs", {28'b0, ov1, s1, co1, of1}, 32'h0);
    chk("rst_w8_outs", {21'b0, ov8, s8, co8, of8}, 32'h0);
    chk("rst_w16_outs", {13'b0, ov16, s16, co16, of16}, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Exhaustive 1-bit truth table, back to back.
    for (int i = 0; i < 8; i++) op1(i);
    idle(3);

    // Carry propagation, overflow and wrap-around on the 4-stage byte adder.
    op8(8'hFF, 8'h00, 1'b1);
    op8(8'h7F, 8'h01, 1'b0);
    op8(8'h80, 8'h80, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1);
    op8(8'h55, 8'hAA, 1'b0);
    op8(8'h3C, 8'h0F, 1'b1);
    idle(6);

    // Single pulse then quiet: one output cycle, result registers hold.
    op8(8'h12, 8'h34, 1'b0);
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      iv8 = 1'b0;
      if (ov8) pulses++;
    end
    chk("hold_pulses", pulses, 1);
    chk("hold_sum", {24'b0, s8}, 32'h46);
    chk("hold_cout", {31'b0, co8}, 32'h0);

    // Throughput: 100 random operations with no gaps.
    for (int i = 0; i < 100; i++) op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    idle(8);
    chk("tput_run_len", last_run16, 100);
    chk("tput_drained", q16.size(), 0);

    // Reset with three operations in flight.
    op16(16'h1234, 16'h4321, 1'b0);
    op16(16'hFFFF, 16'hFFFF, 1'b1);
    op16(16'h8000, 16'h8000, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    iv16 = 1'b0;
    #1;
    chk("midrst_w16_outs", {13'b0, ov16, s16, co16, of16}, 32'h0);
    chk("midrst_w8_outs", {21'b0, ov8, s8, co8, of8}, 32'h0);
    q16.delete();
    #1 rst_n = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov16) stale++;
    end
    chk("midrst_stale_valid", stale, 0);

    op16(16'hFFFF, 16'h0001, 1'b0);
    op16(16'h7FFF, 16'h0000, 1'b1);
    idle(6);

    chk("end_q1_empty", q1.size(), 0);
    chk("end_q8_empty", q8.size(), 0);
    chk("end_q16_empty", q16.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
